seqgen_burst_scheduler: RTL and testbench

- Shares one sequence_generator (clk, rst, enable, 8-bit data) between NREQ requesters.
- Each requester asks for a burst of N words.
- The scheduler arbitrates round-robin, optionally restarts the generator, and drives its enable for exactly N cycles.
- It routes captured data to the granted requester with a per-word valid, then pulses done.

---
 rtl/seqgen_burst_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_seqgen_burst_scheduler.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seqgen_burst_scheduler.sv
// Round-robin scheduler sharing one sequence generator between NREQ requesters.
// Each grant runs an optional generator restart, an N-cycle enable burst and a registered capture stream.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no owner; arbitrate among req starting at the rr pointer
// SETUP | owner granted; gen_rst pulses if the owner asked for restart
// BURST | gen_enable high while the length down-counter runs out
// DRAIN | two cycles for the capture pipeline to flush the last word
// DONE  | done pulse to the owner; pointer advances past the owner
module seqgen_burst_scheduler #(
    parameter int NREQ   = 2,
    parameter int LEN_W  = 4,
    parameter int DATA_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*LEN_W-1:0]   req_len,
    input  logic [NREQ-1:0]         req_restart,
    output logic                    gen_enable,
    output logic                    gen_rst,
    input  logic [DATA_W-1:0]       gen_data,
    output logic [NREQ-1:0]         grant,
    output logic [DATA_W-1:0]       out_data,
    output logic [NREQ-1:0]         out_valid,
    output logic [NREQ-1:0]         done,
    output logic                    busy
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = LEN_W + 1;
    localparam logic [CNT_W-1:0] LEN_MAX = {1'b1, {LEN_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_BURST,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt;
    logic [NREQ-1:0]    grant_nxt, done_nxt;
    logic               gen_enable_nxt, gen_rst_nxt, busy_nxt;
    logic               en_d1;

    logic [NREQ-1:0]    hi_mask, req_hi, arb_onehot;
    logic               arb_hit, arb_rst;
    logic [IDX_W-1:0]   arb_idx;
    logic [LEN_W-1:0]   arb_len;
    logic [CNT_W-1:0]   arb_cnt;

    // Rotating priority: requesters at or above the pointer first, then wrap to the rest.
    always_comb begin
        hi_mask    = '0;
        arb_hit    = 1'b0;
        arb_idx    = '0;
        arb_len    = '0;
        arb_rst    = 1'b0;
        arb_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            hi_mask[i] = (IDX_W'(i) >= ptr);
        end
        req_hi = req & hi_mask;
        for (int i = 0; i < NREQ; i++) begin
            if (!arb_hit && req_hi[i]) begin
                arb_hit       = 1'b1;
                arb_idx       = IDX_W'(i);
                arb_len       = req_len[i*LEN_W +: LEN_W];
                arb_rst       = req_restart[i];
                arb_onehot    = '0;
                arb_onehot[i] = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!arb_hit && req[i]) begin
                arb_hit       = 1'b1;
                arb_idx       = IDX_W'(i);
                arb_len       = req_len[i*LEN_W +: LEN_W];
                arb_rst       = req_restart[i];
                arb_onehot    = '0;
                arb_onehot[i] = 1'b1;
            end
        end
        arb_cnt = (arb_len == '0) ? LEN_MAX : CNT_W'(arb_len);
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        idx_nxt        = idx;
        ptr_nxt        = ptr;
        grant_nxt      = grant;
        done_nxt       = '0;
        gen_enable_nxt = 1'b0;
        gen_rst_nxt    = 1'b0;
        case (state)
            S_IDLE: begin
                grant_nxt = '0;
                if (arb_hit) begin
                    state_nxt   = S_SETUP;
                    idx_nxt     = arb_idx;
                    grant_nxt   = arb_onehot;
                    cnt_nxt     = arb_cnt;
                    gen_rst_nxt = arb_rst;
                end
            end
            S_SETUP: begin
                state_nxt      = S_BURST;
                gen_enable_nxt = 1'b1;
            end
            S_BURST: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = S_DRAIN;
                    cnt_nxt   = CNT_W'(2);
                end else begin
                    cnt_nxt        = cnt - 1'b1;
                    gen_enable_nxt = 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = S_DONE;
                    done_nxt  = grant;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                grant_nxt = '0;
                ptr_nxt   = (idx == IDX_W'(NREQ - 1)) ? '0 : idx + 1'b1;
            end
            default: begin
                state_nxt = S_IDLE;
                grant_nxt = '0;
            end
        endcase
        busy_nxt = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            idx        <= '0;
            ptr        <= '0;
            grant      <= '0;
            done       <= '0;
            gen_enable <= 1'b0;
            gen_rst    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            ptr        <= ptr_nxt;
            grant      <= grant_nxt;
            done       <= done_nxt;
            gen_enable <= gen_enable_nxt;
            gen_rst    <= gen_rst_nxt;
            busy       <= busy_nxt;
        end
    end

    // The generator advances on the enable edge, so its word is valid one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_d1     <= 1'b0;
            out_data  <= '0;
            out_valid <= '0;
        end else begin
            en_d1     <= gen_enable;
            out_valid <= en_d1 ? grant : '0;
            if (en_d1) begin
                out_data <= gen_data;
            end
        end
    end

endmodule

// File: tb/tb_seqgen_burst_scheduler.sv
// Bench for seqgen_burst_scheduler: behavioural add-step generator, burst table and scoreboard of words.
module tb_seqgen_burst_scheduler;

    localparam int NREQ   = 2;
    localparam int LEN_W  = 4;
    localparam int DATA_W = 8;
    localparam logic [7:0] SEED = 8'hA5;
    localparam logic [7:0] STEP = 8'h1D;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*LEN_W-1:0] req_len;
    logic [NREQ-1:0]       req_restart;
    logic                  gen_enable;
    logic                  gen_rst;
    logic [DATA_W-1:0]     gen_data;
    logic [NREQ-1:0]       grant;
    logic [DATA_W-1:0]     out_data;
    logic [NREQ-1:0]       out_valid;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic                  g_rst;

    seqgen_burst_scheduler #(.NREQ(NREQ), .LEN_W(LEN_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .req(req), .req_len(req_len), .req_restart(req_restart),
        .gen_enable(gen_enable), .gen_rst(gen_rst), .gen_data(gen_data), .grant(grant),
        .out_data(out_data), .out_valid(out_valid), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Generator: reset to SEED, add STEP on every enabled edge.
    assign g_rst = rst | gen_rst;
    always @(posedge clk or posedge g_rst) begin
        if (g_rst) gen_data <= SEED;
        else if (gen_enable) gen_data <= gen_data + STEP;
    end

    typedef struct {
        logic [1:0] req;
        logic [3:0] len0;
        logic [3:0] len1;
        logic [1:0] rstv;
        int         exp_idx;
        int         exp_len;
        bit         drop;
    } vec_t;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } sb_t;

    vec_t vec[9];
    sb_t  sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   gen_pos  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic push_burst(input int idx, input int len, input int restart);
        logic [7:0] w;
        if (restart != 0) gen_pos = 0;
        for (int k = 1; k <= len; k++) begin
            w = SEED + STEP * 8'(gen_pos + k);
            sb.push_back('{idx, w});
        end
        gen_pos += len;
    endtask

    task automatic run_burst(input vec_t v);
        int  en_cnt = 0, val_cnt = 0, rst_cnt = 0, cyc = 0;
        int  first_en = -1, first_val = -1, last_val = -1, done_cyc = -1;
        int  rbit;
        bit  seen_grant = 0, seen_done = 0;
        sb_t e;
        rbit        = int'(v.rstv >> v.exp_idx) & 1;
        req         = v.req;
        req_len     = {v.len1, v.len0};
        req_restart = v.rstv;
        push_burst(v.exp_idx, v.exp_len, rbit);
        for (int c = 0; c < 100 && !seen_done; c++) begin
            @(negedge clk);
            cyc++;
            chk("rst_enable_overlap", int'(gen_rst & gen_enable), 0);
            chk("grant_onehot0", int'($onehot0(grant)), 1);
            if (!seen_grant && grant != '0) begin
                seen_grant = 1;
                chk("grant", int'(grant), 1 << v.exp_idx);
            end
            if (gen_rst) rst_cnt++;
            if (gen_enable) begin
                en_cnt++;
                if (first_en < 0) first_en = cyc;
                if (v.drop) req = req & ~(2'b01 << v.exp_idx);
            end
            if (out_valid != '0) begin
                val_cnt++;
                if (first_val < 0) first_val = cyc;
                last_val = cyc;
                chk("scoreboard_nonempty", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("out_valid_owner", int'(out_valid), 1 << e.idx);
                    chk("out_data", int'(out_data), int'(e.data));
                end
            end
            if (done != '0) begin
                seen_done = 1;
                done_cyc  = cyc;
                chk("done_owner", int'(done), 1 << v.exp_idx);
                chk("grant_in_done", int'(grant), 1 << v.exp_idx);
            end
        end
        chk("done_seen", int'(seen_done), 1);
        chk("enable_cycles", en_cnt, v.exp_len);
        chk("valid_words", val_cnt, v.exp_len);
        chk("valid_gapless", last_val - first_val + 1, v.exp_len);
        chk("first_valid_latency", first_val - first_en, 2);
        chk("done_after_last_valid", done_cyc - last_val, 1);
        chk("gen_rst_cycles", rst_cnt, rbit);
        chk("scoreboard_drained", sb.size(), 0);
        @(negedge clk);
        chk("busy_after_done", int'(busy), 0);
        chk("grant_after_done", int'(grant), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit seen_en;
        vec_t v;
        //        req    len0  len1  rstv   idx len drop
        vec[0] = '{2'b11, 4'd2, 4'd4, 2'b00, 0, 2,  1'b0};
        vec[1] = '{2'b11, 4'd2, 4'd4, 2'b00, 1, 4,  1'b0};
        vec[2] = '{2'b11, 4'd2, 4'd4, 2'b00, 0, 2,  1'b0};
        vec[3] = '{2'b11, 4'd2, 4'd4, 2'b00, 1, 4,  1'b0};
        vec[4] = '{2'b01, 4'd3, 4'd0, 2'b01, 0, 3,  1'b0};
        vec[5] = '{2'b01, 4'd1, 4'd0, 2'b00, 0, 1,  1'b0};
        vec[6] = '{2'b01, 4'd0, 4'd0, 2'b00, 0, 16, 1'b0};
        vec[7] = '{2'b10, 4'd0, 4'd5, 2'b10, 1, 5,  1'b0};
        vec[8] = '{2'b01, 4'd6, 4'd3, 2'b00, 0, 6,  1'b1};

        rst = 1'b0;
        req = '0;
        req_len = '0;
        req_restart = '0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_grant", int'(grant), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_gen_enable", int'(gen_enable), 0);
        chk("reset_gen_rst", int'(gen_rst), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_out_data", int'(out_data), 0);
        rst = 1'b0;
        gen_pos = 0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_burst(vec[i]);
        end

        // Abort a 5-word burst of requester 1 in its second enable cycle.
        req = 2'b10;
        req_len = {4'd5, 4'd2};
        req_restart = 2'b00;
        seen_en = 0;
        for (int c = 0; c < 20 && !seen_en; c++) begin
            @(negedge clk);
            if (gen_enable) seen_en = 1;
        end
        chk("abort_burst_started", int'(seen_en), 1);
        chk("abort_owner", int'(grant), 2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_gen_enable", int'(gen_enable), 0);
        chk("abort_grant", int'(grant), 0);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        sb.delete();
        gen_pos = 0;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("no_done_after_abort", int'(done), 0);
            chk("idle_after_abort", int'(busy), 0);
        end
        v = '{2'b11, 4'd2, 4'd5, 2'b00, 0, 2, 1'b0};
        run_burst(v);
        req = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
